// File: rtl/dct_ft_stream.sv
// dct_ft_stream: 8-point fixed-point lifting transform in an
// 8-register valid/ready pipeline with per-lane output saturation.
module dct_ft_stream #(
  parameter int W_I   = 8,
  parameter int W_O   = 16,
  parameter int FRAC  = 3,
  parameter int W_TAG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0][W_I-1:0] in_data,
  input  logic [W_TAG-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0][W_O-1:0] out_data,
  output logic [W_TAG-1:0]    out_tag,
  output logic [7:0]          out_sat
);

  localparam int W_INT = W_I + 4 + FRAC;
  localparam int NS    = 7;

  typedef logic signed [W_INT-1:0] smp_t;

  smp_t                st_q [NS][8];
  smp_t                st_d [NS][8];
  logic [NS-1:0]       vld_q;
  logic [W_TAG-1:0]    tag_q [NS];
  logic                out_valid_q;
  logic [W_TAG-1:0]    out_tag_q;
  logic [7:0][W_O-1:0] out_data_q;
  logic [7:0][W_O-1:0] out_data_d;
  logic [7:0]          out_sat_q;
  logic [7:0]          out_sat_d;
  logic                en;

  // Round to the integer grid, ties away from zero.
  function automatic smp_t rnd(input smp_t v);
    logic inc;
    smp_t fl;
    inc = v[W_INT-1] ? (v[FRAC-1] & (|v[FRAC-2:0]))
                     : v[FRAC-1];
    fl  = v >>> FRAC;
    return (fl + smp_t'(inc)) <<< FRAC;
  endfunction

  function automatic smp_t m38(input smp_t v);
    return (v >>> 3) + (v >>> 2);
  endfunction

  function automatic smp_t m58(input smp_t v);
    return (v >>> 3) + (v >>> 1);
  endfunction

  function automatic smp_t m78(input smp_t v);
    return (v >>> 3) + (v >>> 2) + (v >>> 1);
  endfunction

  function automatic logic [W_O:0] sat_f(input smp_t v);
    int iv;
    int mx;
    int mn;
    iv = int'(v >>> FRAC);
    mx = (1 <<< (W_O - 1)) - 1;
    mn = -mx - 1;
    if (iv > mx) return {1'b1, mx[W_O-1:0]};
    if (iv < mn) return {1'b1, mn[W_O-1:0]};
    return {1'b0, iv[W_O-1:0]};
  endfunction

  assign en        = !rst_n || !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  always_comb begin
    for (int l = 0; l < 8; l++) begin
      st_d[0][l] = smp_t'($signed(in_data[l])) <<< FRAC;
      for (int s = 1; s < NS; s++) begin
        st_d[s][l] = st_q[s-1][l];
      end
    end

    for (int i = 0; i < 4; i++) begin
      st_d[1][i]   = st_q[0][i] + st_q[0][7-i];
      st_d[1][4+i] = st_q[0][3-i] - st_q[0][4+i];
    end

    st_d[2][6] = st_q[1][6] + rnd(m38(st_q[1][5]));

    st_d[3][5] = rnd(m58(st_q[2][6])) - st_q[2][5];

    st_d[4][0] = st_q[3][0] + st_q[3][3];
    st_d[4][1] = st_q[3][1] + st_q[3][2];
    st_d[4][2] = st_q[3][1] - st_q[3][2];
    st_d[4][3] = st_q[3][0] - st_q[3][3];
    st_d[4][4] = st_q[3][4] + st_q[3][5];
    st_d[4][5] = st_q[3][4] - st_q[3][5];
    st_d[4][6] = st_q[3][7] - st_q[3][6];
    st_d[4][7] = st_q[3][7] + st_q[3][6];

    st_d[5][0] = st_q[4][0] + st_q[4][1];
    st_d[5][2] = st_q[4][2] - rnd(m38(st_q[4][3]));
    st_d[5][5] = st_q[4][5] + rnd(m78(st_q[4][6]));

    st_d[6][1] = rnd(st_q[5][0] >>> 1) - st_q[5][1];
    st_d[6][3] = st_q[5][3] + rnd(m38(st_q[5][2]));
    st_d[6][4] = st_q[5][4] - rnd(st_q[5][7] >>> 3);
    st_d[6][6] = st_q[5][6] - rnd(st_q[5][5] >>> 1);

    for (int l = 0; l < 8; l++) begin
      {out_sat_d[l], out_data_d[l]} = sat_f(st_q[6][l]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) begin
        tag_q[s] <= '0;
        for (int l = 0; l < 8; l++) begin
          st_q[s][l] <= '0;
        end
      end
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else if (en) begin
      st_q     <= st_d;
      vld_q    <= {vld_q[NS-2:0], in_valid};
      tag_q[0] <= in_tag;
      for (int s = 1; s < NS; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
      out_valid_q <= vld_q[NS-1];
      out_tag_q   <= tag_q[NS-1];
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_dct_ft_stream.sv
// Bench for dct_ft_stream: vector table, scoreboard, backpressure,
// throughput and mid-stream reset sequences on W_O=16 and W_O=10 copies.
module tb_dct_ft_stream;

  localparam int W_I   = 8;
  localparam int W_O   = 16;
  localparam int W_O2  = 10;
  localparam int FRAC  = 3;
  localparam int W_TAG = 4;
  localparam int SC    = 1 << FRAC;
  localparam int NR    = 8;

  typedef logic [7:0][W_I-1:0] din_t;
  typedef logic [7:0][15:0]    e16_t;

  typedef struct packed {
    logic [W_TAG-1:0] tag;
    e16_t             e;
    logic [7:0]       s;
    e16_t             e2;
    logic [7:0]       s2;
  } exp_t;

  typedef struct packed {
    din_t             d;
    logic [W_TAG-1:0] tag;
    logic             cst;
    e16_t             e;
    logic [7:0]       s;
    logic [15:0]      e10;
    logic [7:0]       s10;
  } row_t;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_ready2;
  din_t                 in_data;
  logic [W_TAG-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_valid2;
  logic                 out_ready;
  logic [7:0][W_O-1:0]  out_data;
  logic [7:0][W_O2-1:0] out_data2;
  logic [W_TAG-1:0]     out_tag;
  logic [W_TAG-1:0]     out_tag2;
  logic [7:0]           out_sat;
  logic [7:0]           out_sat2;

  dct_ft_stream #(
    .W_I(W_I), .W_O(W_O), .FRAC(FRAC), .W_TAG(W_TAG)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_sat(out_sat)
  );

  dct_ft_stream #(
    .W_I(W_I), .W_O(W_O2), .FRAC(FRAC), .W_TAG(W_TAG)
  ) dut10 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_tag(out_tag2), .out_sat(out_sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  bit   tp_arm = 0;
  int   tp_q[$];
  row_t tbl [NR];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  function automatic int fdiv(input int v, input int d);
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int rr(input int v);
    int q;
    int r;
    q = fdiv(v, SC);
    r = v - q * SC;
    if (v >= 0 ? (r >= SC / 2) : (r > SC / 2)) q = q + 1;
    return q * SC;
  endfunction

  function automatic void model(input din_t d, input int wo,
                                output e16_t e, output logic [7:0] s);
    int x[8];
    int a[8];
    int b[8];
    int iv;
    int mx;
    for (int i = 0; i < 8; i++) x[i] = $signed(d[i]) * SC;
    for (int i = 0; i < 4; i++) begin
      a[i]   = x[i] + x[7-i];
      a[4+i] = x[3-i] - x[4+i];
    end
    a[6] = a[6] + rr(fdiv(a[5], 8) + fdiv(a[5], 4));
    a[5] = rr(fdiv(a[6], 8) + fdiv(a[6], 2)) - a[5];
    b[0] = a[0] + a[3]; b[1] = a[1] + a[2];
    b[2] = a[1] - a[2]; b[3] = a[0] - a[3];
    b[4] = a[4] + a[5]; b[5] = a[4] - a[5];
    b[6] = a[7] - a[6]; b[7] = a[7] + a[6];
    b[0] = b[0] + b[1];
    b[2] = b[2] - rr(fdiv(b[3], 8) + fdiv(b[3], 4));
    b[5] = b[5] + rr(fdiv(b[6], 8) + fdiv(b[6], 4) + fdiv(b[6], 2));
    b[1] = rr(fdiv(b[0], 2)) - b[1];
    b[3] = b[3] + rr(fdiv(b[2], 8) + fdiv(b[2], 4));
    b[4] = b[4] - rr(fdiv(b[7], 8));
    b[6] = b[6] - rr(fdiv(b[5], 2));
    mx = (1 << (wo - 1)) - 1;
    for (int i = 0; i < 8; i++) begin
      iv   = fdiv(b[i], SC);
      s[i] = 1'b0;
      if (iv > mx) begin
        iv = mx; s[i] = 1'b1;
      end else if (iv < -mx - 1) begin
        iv = -mx - 1; s[i] = 1'b1;
      end
      e[i] = iv[15:0];
    end
  endfunction

  function automatic exp_t mk_exp(input din_t d, input logic [W_TAG-1:0] t);
    exp_t x;
    x.tag = t;
    model(d, W_O, x.e, x.s);
    model(d, W_O2, x.e2, x.s2);
    return x;
  endfunction

  function automatic din_t dc(input logic [7:0] v);
    return {8{v}};
  endfunction

  task automatic chk_out();
    exp_t x;
    bit   bad;
    x = sb.pop_front();
    bad = (out_tag !== x.tag) || (out_sat !== x.s);
    for (int i = 0; i < 8; i++) bad |= (out_data[i] !== x.e[i]);
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL out16 got tag %h sat %h data %h want tag %h sat %h data %h",
               out_tag, out_sat, out_data, x.tag, x.s, x.e);
    end
    bad = !out_valid2 || (out_tag2 !== x.tag) || (out_sat2 !== x.s2);
    for (int i = 0; i < 8; i++) bad |= (out_data2[i] !== x.e2[i][W_O2-1:0]);
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL out10 got tag %h sat %h data %h want tag %h sat %h data %h",
               out_tag2, out_sat2, out_data2, x.tag, x.s2, x.e2);
    end
  endtask

  bit                  hold_v = 0;
  logic [7:0][W_O-1:0] hold_d;
  logic [W_TAG-1:0]    hold_t;
  logic [7:0]          hold_s;

  always @(negedge clk) begin
    if (!mon_en) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        n_cmp++;
        if (!out_valid || out_data !== hold_d || out_tag !== hold_t ||
            out_sat !== hold_s) begin
          n_err++;
          $display("FAIL stall_hold got v %b data %h want v 1 data %h",
                   out_valid, out_data, hold_d);
        end
      end
      hold_v = 0;
      if (tp_arm && out_valid) tp_q.push_back(cyc);
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out got tag %h data %h want none",
                     out_tag, out_data);
          end else begin
            chk_out();
          end
        end else begin
          hold_v = 1;
          hold_d = out_data;
          hold_t = out_tag;
          hold_s = out_sat;
        end
      end
    end
  end

  task automatic step(input bit rnd);
    @(posedge clk);
    #1;
    out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic send(input din_t d, input logic [W_TAG-1:0] t,
                      input exp_t x, input bit rnd);
    bit acc;
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    do begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sb.push_back(x);
      step(rnd);
      guard++;
    end while (!acc && guard < 200);
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && guard < 300) begin
      step(0);
      guard++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    din_t             d;
    exp_t             x;
    logic [W_TAG-1:0] t;
    int               t0;
    int               first;

    for (int r = 0; r < NR; r++) tbl[r] = '0;
    tbl[0].d = dc(8'd100);        tbl[0].tag = 4'h1; tbl[0].cst = 1;
    tbl[0].e[0] = 16'd800;        tbl[0].e10 = 16'd511; tbl[0].s10 = 8'h01;
    tbl[1].d = din_t'(64'h1);     tbl[1].tag = 4'h2;
    tbl[2].d = dc(8'h9c);         tbl[2].tag = 4'h3; tbl[2].cst = 1;
    tbl[2].e[0] = 16'hfce0;       tbl[2].e10 = 16'hfe00; tbl[2].s10 = 8'h01;
    tbl[3].d = dc(8'd127);        tbl[3].tag = 4'h4; tbl[3].cst = 1;
    tbl[3].e[0] = 16'd1016;       tbl[3].e10 = 16'd511; tbl[3].s10 = 8'h01;
    tbl[4].d = dc(8'h80);         tbl[4].tag = 4'h5; tbl[4].cst = 1;
    tbl[4].e[0] = 16'hfc00;       tbl[4].e10 = 16'hfe00; tbl[4].s10 = 8'h01;
    tbl[5].d = 64'h807f807f807f807f; tbl[5].tag = 4'h6;
    tbl[6].d = 64'h04030201_00fffefd; tbl[6].tag = 4'h7;
    tbl[7].d = 64'hff000000_00000000; tbl[7].tag = 4'h8;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {out_valid, out_valid2}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat_tag", {out_sat, out_tag}, 0);
    chk("rst_ready", {in_ready, in_ready2}, 2'b11);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mon_en    = 1;
    out_ready = 1'b1;

    for (int r = 0; r < NR; r++) begin
      x = mk_exp(tbl[r].d, tbl[r].tag);
      if (tbl[r].cst) begin
        x.e     = tbl[r].e;
        x.s     = tbl[r].s;
        x.e2    = '0;
        x.e2[0] = tbl[r].e10;
        x.s2    = tbl[r].s10;
      end
      send(tbl[r].d, tbl[r].tag, x, 0);
    end
    drain();

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
      t = W_TAG'($urandom);
      if ($urandom_range(0, 3) == 0) step(1);
      send(d, t, mk_exp(d, t), 1);
    end
    drain();

    tp_q.delete();
    tp_arm = 1;
    t0 = cyc;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
      t = W_TAG'(n);
      send(d, t, mk_exp(d, t), 0);
    end
    drain();
    repeat (4) step(0);
    tp_arm = 0;
    first = (tp_q.size() > 0) ? tp_q[0] : -1;
    chk("tp_count", tp_q.size(), 16);
    chk("tp_first", first, t0 + 8);
    chk("tp_last", (tp_q.size() > 0) ? tp_q[$] : -1, t0 + 23);

    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
      t = W_TAG'(n + 9);
      send(d, t, mk_exp(d, t), 0);
    end
    rst_n  = 1'b0;
    mon_en = 0;
    sb.delete();
    @(negedge clk);
    chk("midrst_ready", {in_ready, in_ready2}, 2'b11);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {out_valid, out_valid2}, 0);
    mon_en = 1;
    repeat (20) step(0);

    tp_q.delete();
    tp_arm = 1;
    t0 = cyc;
    d = dc(8'd100);
    x = mk_exp(d, 4'hc);
    send(d, 4'hc, x, 0);
    drain();
    repeat (4) step(0);
    tp_arm = 0;
    chk("post_rst_count", tp_q.size(), 1);
    chk("post_rst_lat", (tp_q.size() > 0) ? tp_q[0] : -1, t0 + 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
